// File: rtl/cla_subtractor_pipe_if.sv
// Valid/ready beat interface for the pipelined carry-lookahead subtractor.
// The subtractor uses the slave modport. The source/sink side uses the master modport.
interface cla_subtractor_pipe_if #(
  parameter int WIDTH = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_min;
  logic [WIDTH-1:0] i_sub;
  logic             i_bin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;
  logic             o_overflow;
  logic             o_zero;

  modport master (
    output i_valid, i_min, i_sub, i_bin, i_ready,
    input  o_ready, o_valid, o_diff, o_borrow, o_overflow, o_zero
  );

  modport slave (
    input  i_valid, i_min, i_sub, i_bin, i_ready,
    output o_ready, o_valid, o_diff, o_borrow, o_overflow, o_zero
  );
endinterface

// File: rtl/cla_subtractor_pipe.sv
// Pipelined two's-complement subtractor (min - sub - bin).
// Each stage resolves one GROUP-bit carry-lookahead block, and a single enable stalls the whole pipe.
module cla_subtractor_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_subtractor_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / GROUP;

  // Returns {carry_out, sum} for min + ~sub + cin.
  // Every carry is the fully expanded generate/propagate sum of products.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                               input logic [GROUP-1:0] b,
                                               input logic             cin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             term;
    g = a & ~b;
    p = a | ~b;
    for (int i = 0; i <= GROUP; i++) begin
      c[i] = cin;
      for (int k = 0; k < i; k++) c[i] = c[i] & p[k];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    return {c[GROUP], a ^ ~b ^ c[GROUP-1:0]};
  endfunction

  logic             adv;
  logic             vld_p [0:STAGES];
  logic [WIDTH-1:0] min_p [0:STAGES-1];
  logic [WIDTH-1:0] sub_p [0:STAGES-1];
  logic [WIDTH-1:0] dif_p [0:STAGES-1];
  logic             cry_p [0:STAGES-1];
  logic [GROUP:0]   grp_res [0:STAGES-1];
  logic [WIDTH-1:0] diff_nxt;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;

  assign adv         = ~vld_p[STAGES] | bus.i_ready;
  assign bus.o_ready = adv;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      grp_res[k] = cla_group(min_p[k][k*GROUP +: GROUP], sub_p[k][k*GROUP +: GROUP], cry_p[k]);
    end
    diff_nxt = dif_p[STAGES-1];
    diff_nxt[WIDTH-1 -: GROUP] = grp_res[STAGES-1][GROUP-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= STAGES; k++) vld_p[k] <= 1'b0;
    end else if (adv) begin
      vld_p[0] <= bus.i_valid;
      for (int k = 0; k < STAGES; k++) vld_p[k+1] <= vld_p[k];
    end
  end

  // Stage boundary k -> k+1: operands travel along, and sum group k joins the lower groups already resolved.
  always_ff @(posedge clk) begin
    if (adv) begin
      min_p[0] <= bus.i_min;
      sub_p[0] <= bus.i_sub;
      cry_p[0] <= ~bus.i_bin;
      dif_p[0] <= '0;
      for (int k = 0; k < STAGES - 1; k++) begin
        min_p[k+1] <= min_p[k];
        sub_p[k+1] <= sub_p[k];
        cry_p[k+1] <= grp_res[k][GROUP];
        dif_p[k+1] <= dif_p[k];
        dif_p[k+1][k*GROUP +: GROUP] <= grp_res[k][GROUP-1:0];
      end
    end
  end

  // Output boundary: the top group completes, and the flags are registered with the difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (adv) begin
      diff_q   <= diff_nxt;
      borrow_q <= ~grp_res[STAGES-1][GROUP];
      ovf_q    <= (min_p[STAGES-1][WIDTH-1] != sub_p[STAGES-1][WIDTH-1]) &
                  (diff_nxt[WIDTH-1] != min_p[STAGES-1][WIDTH-1]);
    end
  end

  assign bus.o_valid    = vld_p[STAGES];
  assign bus.o_diff     = diff_q;
  assign bus.o_borrow   = borrow_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_zero     = vld_p[STAGES] & (diff_q == '0);
endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Scoreboard bench for cla_subtractor_pipe (WIDTH=8, GROUP=4, latency 2).
// Directed vectors are paired with hand-computed results, followed by a randomized stream checked against an integer model.
module tb_cla_subtractor_pipe;
  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   beat_n = 0;
  exp_t exp_q[$];
  bit   rdone;
  bit   seen;

  cla_subtractor_pipe_if #(.WIDTH(8)) bus ();

  cla_subtractor_pipe #(.WIDTH(8), .GROUP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Presents one beat and pushes its expected result once the beat is sure to be accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] d, input logic bo, input logic ov, input logic z);
    bit done;
    exp_t e;
    done = 0;
    bus.i_valid = 1'b1;
    bus.i_min   = a;
    bus.i_sub   = b;
    bus.i_bin   = bin;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        e.d = d; e.bo = bo; e.ov = ov; e.z = z;
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    if (!done) chk("send_accept_timeout", 0, 1);
  endtask

  task automatic lat_chk(input string nm);
    chk({nm, "_valid_edge0"}, bus.o_valid, 0);
    @(posedge clk); #1;
    chk({nm, "_valid_edge1"}, bus.o_valid, 0);
    @(posedge clk); #1;
    chk({nm, "_valid_edge2"}, bus.o_valid, 1);
    @(posedge clk); #1;
  endtask

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                output logic [7:0] d, output logic bo, output logic ov,
                                output logic z);
    int u;
    int s;
    u  = int'(a) - int'(b) - int'(bin);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = u[7:0];
    bo = (u < 0);
    ov = (s < -128) || (s > 127);
    z  = (d == 8'h00);
  endfunction

  // Monitor: compares the head of the scoreboard on every valid cycle, so held outputs are rechecked during a stall.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (bus.o_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_o_valid", 1, 0);
        end else begin
          e = exp_q[0];
          checks++;
          if (bus.o_diff !== e.d || bus.o_borrow !== e.bo ||
              bus.o_overflow !== e.ov || bus.o_zero !== e.z) begin
            failures++;
            $display("FAIL beat%0d: got diff=%h b=%b v=%b z=%b expected diff=%h b=%b v=%b z=%b",
                     beat_n, bus.o_diff, bus.o_borrow, bus.o_overflow, bus.o_zero,
                     e.d, e.bo, e.ov, e.z);
          end
          if (bus.i_ready) begin
            void'(exp_q.pop_front());
            beat_n++;
          end
        end
      end else begin
        chk("zero_while_invalid", bus.o_zero, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b, d;
    logic       bin, bo, ov, z;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_min = 8'h00;
    bus.i_sub = 8'h00;
    bus.i_bin = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_o_ready_during", bus.o_ready, 1);
    chk("rst_o_valid_during", bus.o_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_diff", bus.o_diff, 0);
    chk("rst_o_borrow", bus.o_borrow, 0);
    chk("rst_o_overflow", bus.o_overflow, 0);
    chk("rst_o_zero", bus.o_zero, 0);
    chk("rst_o_ready_after", bus.o_ready, 1);

    // Directed vectors
    send(8'h50, 8'h20, 1'b0, 8'h30, 0, 0, 0);
    lat_chk("basic");
    send(8'h20, 8'h50, 1'b0, 8'hD0, 1, 0, 0);
    send(8'h80, 8'h01, 1'b0, 8'h7F, 0, 1, 0);
    send(8'h7F, 8'hFF, 1'b0, 8'h80, 1, 1, 0);
    send(8'h33, 8'h33, 1'b0, 8'h00, 0, 0, 1);
    send(8'h33, 8'h33, 1'b1, 8'hFF, 1, 0, 0);
    send(8'h00, 8'h00, 1'b1, 8'hFF, 1, 0, 0);
    send(8'h80, 8'h00, 1'b1, 8'h7F, 0, 1, 0);
    send(8'hFF, 8'hFF, 1'b0, 8'h00, 0, 0, 1);
    send(8'h0F, 8'hF1, 1'b0, 8'h1E, 1, 0, 0);
    repeat (4) @(posedge clk);
    #1;

    // Back-pressure
    seen = 0;
    fork
      begin
        send(8'h10, 8'h01, 1'b0, 8'h0F, 0, 0, 0);
        send(8'h20, 8'h02, 1'b0, 8'h1E, 0, 0, 0);
        send(8'h30, 8'h03, 1'b0, 8'h2D, 0, 0, 0);
        send(8'h40, 8'h04, 1'b0, 8'h3C, 0, 0, 0);
      end
      begin
        for (int t = 0; t < 20 && !seen; t++) begin
          @(posedge clk); #1;
          if (bus.o_valid) seen = 1;
        end
        chk("bp_first_valid", seen, 1);
        bus.i_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
          @(negedge clk);
          chk("bp_o_ready_low", bus.o_ready, 0);
          chk("bp_hold_diff", bus.o_diff, 8'h0F);
          @(posedge clk); #1;
        end
        bus.i_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("bp_drained", exp_q.size(), 0);

    // Reset mid-flight
    send(8'h11, 8'h01, 1'b0, 8'h10, 0, 0, 0);
    send(8'h22, 8'h02, 1'b0, 8'h20, 0, 0, 0);
    rst = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_min = 8'hAA;
    bus.i_sub = 8'h55;
    @(negedge clk);
    chk("midrst_o_ready", bus.o_ready, 1);
    @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
    bus.i_valid = 1'b0;
    chk("midrst_o_valid", bus.o_valid, 0);
    chk("midrst_o_diff", bus.o_diff, 0);
    chk("midrst_o_borrow", bus.o_borrow, 0);
    chk("midrst_o_overflow", bus.o_overflow, 0);
    chk("midrst_o_zero", bus.o_zero, 0);
    send(8'h05, 8'h03, 1'b0, 8'h02, 0, 0, 0);
    lat_chk("postrst");
    repeat (4) @(posedge clk);
    #1;

    // Randomized stream with random gaps and random back-pressure
    rdone = 0;
    fork
      begin
        for (int n = 0; n < 2000; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          a = 8'($urandom);
          b = 8'($urandom);
          bin = 1'($urandom);
          model(a, b, bin, d, bo, ov, z);
          send(a, b, bin, d, bo, ov, z);
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          bus.i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.i_ready = 1'b1;

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("final_drain_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
